// File: rtl/bcd_digit_extractor_seq.sv
// Sequential binary-to-BCD extractor: one input bit per clock using shift-add-3.
// The result is registered and held between conversions. Values above the
// digit capacity saturate the digits to all 9s and raise overflow.
module bcd_digit_extractor_seq #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned DIGITS   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   input_number,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  overflow
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(IN_WIDTH + 1);
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    logic [IN_WIDTH-1:0]  shift_reg;
    logic [BCD_W-1:0]     scratch;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 ovf_int;

    logic [BCD_W-1:0]     adj_c;
    logic [BCD_W-1:0]     scratch_nxt_c;
    logic [IN_WIDTH-1:0]  shift_nxt_c;
    logic                 carry_c;
    logic                 ovf_nxt_c;

    // One shift-add-3 step: correct digits >= 5, then shift scratch:shift_reg left.
    always_comb begin
        adj_c = scratch;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (scratch[4*k +: 4] >= 4'd5) begin
                adj_c[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
            end
        end
        {carry_c, scratch_nxt_c, shift_nxt_c} = {adj_c, shift_reg, 1'b0};
        ovf_nxt_c = ovf_int | carry_c;
    end

    // Control FSM with datapath registers and registered handshake/result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            scratch   <= '0;
            bit_cnt   <= '0;
            ovf_int   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            digits    <= '0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        shift_reg <= input_number;
                        scratch   <= '0;
                        ovf_int   <= 1'b0;
                        bit_cnt   <= CNT_W'(IN_WIDTH);
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_nxt_c;
                    scratch   <= scratch_nxt_c;
                    ovf_int   <= ovf_nxt_c;
                    bit_cnt   <= bit_cnt - CNT_W'(1);
                    // Last bit: publish the result as DONE is entered.
                    if (bit_cnt == CNT_W'(1)) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        overflow <= ovf_nxt_c;
                        digits   <= ovf_nxt_c ? ALL_NINES : scratch_nxt_c;
                        state    <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_digit_extractor_seq.sv
// Bench for bcd_digit_extractor_seq: three instances (8b/3d, 8b/2d, 3b/1d)
// checked against an arithmetic decimal model.
module tb_bcd_digit_extractor_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance 0: defaults (IN_WIDTH=8, DIGITS=3)
    logic        start_a;
    logic [7:0]  in_a;
    logic        busy_a, done_a, ovf_a;
    logic [11:0] dig_a;
    // Instance 1: IN_WIDTH=8, DIGITS=2
    logic        start_b;
    logic [7:0]  in_b;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  dig_b;
    // Instance 2: IN_WIDTH=3, DIGITS=1
    logic        start_c;
    logic [2:0]  in_c;
    logic        busy_c, done_c, ovf_c;
    logic [3:0]  dig_c;

    bcd_digit_extractor_seq #(.IN_WIDTH(8), .DIGITS(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .input_number(in_a),
        .busy(busy_a), .done(done_a), .digits(dig_a), .overflow(ovf_a));

    bcd_digit_extractor_seq #(.IN_WIDTH(8), .DIGITS(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .input_number(in_b),
        .busy(busy_b), .done(done_b), .digits(dig_b), .overflow(ovf_b));

    bcd_digit_extractor_seq #(.IN_WIDTH(3), .DIGITS(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .input_number(in_c),
        .busy(busy_c), .done(done_c), .digits(dig_c), .overflow(ovf_c));

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Decimal digits of v, or all 9s when v does not fit in nd digits.
    function automatic logic [31:0] ref_bcd(input int unsigned v, input int unsigned nd);
        logic [31:0] r;
        int unsigned lim;
        int unsigned x;
        r   = '0;
        lim = 1;
        for (int i = 0; i < int'(nd); i++) lim = lim * 10;
        x = v;
        for (int i = 0; i < int'(nd); i++) begin
            r[4*i +: 4] = (v >= lim) ? 4'h9 : 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int unsigned v, input int unsigned nd);
        int unsigned lim;
        lim = 1;
        for (int i = 0; i < int'(nd); i++) lim = lim * 10;
        return v >= lim;
    endfunction

    function automatic int unsigned inst_width(input int inst);
        return (inst == 2) ? 3 : 8;
    endfunction

    function automatic int unsigned inst_digits(input int inst);
        return (inst == 0) ? 3 : ((inst == 1) ? 2 : 1);
    endfunction

    function automatic logic get_busy(input int inst);
        return (inst == 0) ? busy_a : ((inst == 1) ? busy_b : busy_c);
    endfunction

    function automatic logic get_done(input int inst);
        return (inst == 0) ? done_a : ((inst == 1) ? done_b : done_c);
    endfunction

    function automatic logic get_ovf(input int inst);
        return (inst == 0) ? ovf_a : ((inst == 1) ? ovf_b : ovf_c);
    endfunction

    function automatic logic [31:0] get_digits(input int inst);
        return (inst == 0) ? 32'(dig_a) : ((inst == 1) ? 32'(dig_b) : 32'(dig_c));
    endfunction

    task automatic drive(input int inst, input logic s, input int unsigned v);
        case (inst)
            0:       begin start_a = s; in_a = 8'(v); end
            1:       begin start_b = s; in_b = 8'(v); end
            default: begin start_c = s; in_c = 3'(v); end
        endcase
    endtask

    // Request a conversion now (accepted at the next edge), follow it to done.
    // disturb_at > 0 pulses start with a new input in that busy cycle.
    task automatic convert(input int inst, input int unsigned val, input int disturb_at);
        int unsigned w;
        int unsigned nd;
        int          n;
        logic        seen;
        int unsigned cur_in;
        w      = inst_width(inst);
        nd     = inst_digits(inst);
        cur_in = val;
        drive(inst, 1'b1, val);
        @(posedge clk); #1;
        drive(inst, 1'b0, cur_in);
        n    = 1;
        seen = 1'b0;
        while (n <= int'(w) + 4) begin
            if (get_done(inst)) begin
                seen = 1'b1;
                break;
            end
            check("busy_during_conv", 32'(get_busy(inst)), 32'd1);
            if (disturb_at > 0 && n == disturb_at) begin
                cur_in = 17;
                drive(inst, 1'b1, cur_in);
            end else begin
                drive(inst, 1'b0, cur_in);
            end
            @(posedge clk); #1;
            n++;
        end
        drive(inst, 1'b0, cur_in);
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(n), 32'(w + 1));
        check("busy_at_done", 32'(get_busy(inst)), 32'd0);
        check("digits", get_digits(inst), ref_bcd(val, nd));
        check("overflow", 32'(get_ovf(inst)), 32'(ref_ovf(val, nd)));
    endtask

    // Quiet cycles: no done, no busy, result held.
    task automatic idle(input int inst, input int cycles);
        logic [31:0] held;
        held = get_digits(inst);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            check("no_extra_done", 32'(get_done(inst)), 32'd0);
            check("idle_busy", 32'(get_busy(inst)), 32'd0);
            check("digits_held", get_digits(inst), held);
        end
    endtask

    initial begin
        int unsigned v;
        rst_n = 1'b0;
        drive(0, 1'b0, 0);
        drive(1, 1'b0, 0);
        drive(2, 1'b0, 0);
        #12;
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_digits", 32'(dig_a), 32'd0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(0, 2);

        // Full-scale value and back-to-back conversions with start held in DONE
        convert(0, 255, 0);
        idle(0, 2);
        convert(0, 0, 0);
        convert(0, 9, 0);
        idle(0, 2);

        // Start and input change mid-conversion are ignored
        convert(0, 128, 3);
        idle(0, 3);

        // Two-digit instance: saturation then recovery
        convert(1, 200, 0);
        idle(1, 1);
        convert(1, 42, 0);
        convert(1, 99, 0);
        convert(1, 100, 0);

        // Legacy 3-bit, 1-digit configuration, exhaustive
        for (int i = 0; i < 8; i++) begin
            convert(2, i, 0);
            idle(2, 1);
        end

        // Randomized values on both 8-bit instances
        for (int i = 0; i < 25; i++) begin
            v = $urandom_range(0, 255);
            convert(0, v, 0);
            if ($urandom_range(0, 1) == 1) idle(0, 1);
        end
        for (int i = 0; i < 15; i++) begin
            v = $urandom_range(0, 255);
            convert(1, v, 0);
        end

        // Asynchronous reset mid-conversion
        convert(0, 255, 0);
        drive(0, 1'b1, 200);
        @(posedge clk); #1;
        drive(0, 1'b0, 200);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy_a), 32'd0);
        check("arst_done", 32'(done_a), 32'd0);
        check("arst_digits", 32'(dig_a), 32'd0);
        check("arst_ovf", 32'(ovf_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(0, 12);
        convert(0, 99, 0);
        idle(0, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_digit_extractor_seq.md
Name: bcd_digit_extractor_seq

Overview:
Sequential, parametrised binary-to-BCD digit extractor. It generalises the team's single-digit combinational extractor to any input width and digit count, using an iterative shift-add-3 ("double dabble") core that processes one input bit per clock. It uses a start/busy/done handshake and a registered, held result, and adds overflow detection when the value exceeds the digit capacity. It sits between arithmetic blocks (ALU/counter results) and the 7-segment display drivers.

Parameters:
IN_WIDTH, 8, width of the unsigned binary input (legal 1..32).
DIGITS, 3, number of BCD output digits (legal 1..10); digit 0 is least significant.

Ports:
clk  input  1  system clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a conversion; sampled only when the block can accept one.
input_number  input  IN_WIDTH  unsigned binary value; captured on the accepted start cycle only.
busy  output  1  high while a conversion is in progress.
done  output  1  single-cycle pulse when digits/overflow are updated.
digits  output  4*DIGITS  packed BCD result; digit k is at bits [4k+3:4k]; held between conversions.
overflow  output  1  high if the last result exceeded 10^DIGITS-1; held with digits.

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE, busy=0, done=0, digits=0, overflow=0, internal shift/BCD registers cleared. Reset mid-conversion aborts it; no done pulse follows.
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0. If start=1, capture input_number into the shift register, clear the BCD scratch digits, load bit counter=IN_WIDTH, and go to SHIFT.
- SHIFT: busy=1. Each cycle, first add 3 to every scratch digit >=5. Then shift {scratch, shift_reg} left by 1. A 1 shifted out of the top scratch digit sets the sticky ovf_int. Decrement the counter; after exactly IN_WIDTH SHIFT cycles, go to DONE.
- DONE (one cycle): done=1, busy=0. On entry, digits<=scratch and overflow<=ovf_int. If ovf_int=1, digits saturate to all 9s (4'h9 per digit). Next state is IDLE. A start in DONE is accepted exactly as in IDLE, allowing back-to-back conversions.
- start in SHIFT is ignored and not queued. input_number changes outside the accept cycle have no effect.
- Latency: start accepted at edge T gives done=1 in cycle T+IN_WIDTH+1. Throughput is one conversion per IN_WIDTH+1 cycles.
- digits/overflow change only at DONE entry or reset. Between conversions they hold their last value.
- Width rules: scratch is 4*DIGITS bits. Overflow is also detected from the shift-out path, so the block needs no extra guard digit. Each digit stays in 0..9 at all times after add-3.
- IN_WIDTH=3, DIGITS=1 reproduces the legacy single-digit extractor (values 0..7, overflow never set).
- busy and done are never high in the same cycle.

Test Plan:
- Defaults, input 8'd255, start pulse at T -> busy high T+1..T+8, done pulse at T+9, digits=12'h255, overflow=0.
- Defaults, input 8'd0 then 8'd9, back-to-back with start held during DONE -> digits 12'h000 then 12'h009, done pulses 9 cycles apart.
- DIGITS=2 instance, input 8'd200 -> done at T+9, overflow=1, digits=8'h99. Next conversion of 8'd42 gives overflow=0, digits=8'h42.
- Start pulsed and input_number changed to 8'd17 at T+3 of a 8'd128 conversion -> ignored; result 12'h128, a single done pulse.
- rst_n low at T+4 mid-conversion -> busy, done, digits and overflow all 0 immediately (asynchronous), no done pulse. A fresh conversion of 8'd99 then gives 12'h099.
- IN_WIDTH=3, DIGITS=1, exhaustive 0..7 -> digits equals input value, overflow=0, done at T+4 each time.
